scram_codec: RTL and testbench

- Parametrised self-synchronous scrambler/descrambler for the data encrypt/decrypt path. It generalises the 5-stage serial descrambler to configurable register length and tap set, N bits per clock, and a per-beat scramble/descramble mode.
- It adds a valid/ready handshake with a registered output stage and a lock indicator.
- Sits between the serial/parallel link framing and the payload logic.

---
 rtl/scram_codec_if.sv | 23 ++
 rtl/scram_codec.sv | 99 +++++++++
 tb/tb_scram_codec.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scram_codec_if.sv
// Beat stream between the link framing side and the payload side of scram_codec.
// The codec takes the slave view; the upstream/downstream logic uses the master view.
interface scram_codec_if #(
  parameter int DATA_W = 8
);
  logic              i_mode;
  logic              i_valid;
  logic [DATA_W-1:0] i_data;
  logic              o_ready;
  logic              o_valid;
  logic [DATA_W-1:0] o_data;
  logic              i_ready;

  modport slave (
    input  i_mode, i_valid, i_data, i_ready,
    output o_ready, o_valid, o_data
  );

  modport master (
    output i_mode, i_valid, i_data, i_ready,
    input  o_ready, o_valid, o_data
  );
endinterface

// File: rtl/scram_codec.sv
// Self-synchronous scrambler/descrambler: DATA_W bits per beat through a LFSR_LEN-bit
// shift register of coded bits, with a registered valid/ready output and lock flag.
module scram_codec #(
  parameter int                  LFSR_LEN = 5,
  parameter logic [LFSR_LEN-1:0] TAPS     = 5'b00101,
  parameter int                  DATA_W   = 8
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_clear,
  scram_codec_if.slave    bus,
  output logic            o_lock
);

  localparam int CNT_W = $clog2(LFSR_LEN + 1);
  localparam int SUM_W = CNT_W + 7;

  typedef struct packed {
    logic [LFSR_LEN-1:0] state;
    logic [DATA_W-1:0]   dout;
  } beat_t;

  // Bit k sees the register already advanced by bits 0..k-1; the output is d^fb in
  // both modes, only the bit fed back differs (the coded bit is always shifted in).
  function automatic beat_t run_beat(input logic [LFSR_LEN-1:0] state,
                                     input logic [DATA_W-1:0]   din,
                                     input logic                descr);
    beat_t r;
    logic  fb;
    logic  coded;
    r.state = state;
    r.dout  = '0;
    for (int k = 0; k < DATA_W; k++) begin
      fb        = ^(r.state & TAPS);
      r.dout[k] = din[k] ^ fb;
      coded     = descr ? din[k] : r.dout[k];
      r.state   = {coded, r.state[LFSR_LEN-1:1]};
    end
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] cnt);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(cnt) + SUM_W'(DATA_W);
    if (sum >= SUM_W'(LFSR_LEN)) return CNT_W'(LFSR_LEN);
    return sum[CNT_W-1:0];
  endfunction

  logic [LFSR_LEN-1:0] r_shift;
  logic [CNT_W-1:0]    lock_cnt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic                lock_p1;
  logic                vld_p1;
  logic [DATA_W-1:0]   data_p1;
  logic                ready;
  logic                accept;
  beat_t               beat_p0;

  // p0: unrolled bit chain and handshake decision
  assign ready   = ~vld_p1 | bus.i_ready;
  assign accept  = bus.i_valid & ready & ~i_clear;
  assign beat_p0 = run_beat(r_shift, bus.i_data, bus.i_mode);
  assign cnt_nxt = sat_cnt(lock_cnt);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift  <= '0;
      lock_cnt <= '0;
      lock_p1  <= 1'b0;
    end else if (i_clear) begin
      r_shift  <= '0;
      lock_cnt <= '0;
      lock_p1  <= 1'b0;
    end else if (accept) begin
      r_shift  <= beat_p0.state;
      lock_cnt <= cnt_nxt;
      lock_p1  <= (cnt_nxt == CNT_W'(LFSR_LEN));
    end
  end

  // p1: output register; a pending beat is unaffected by i_clear
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else if (accept) begin
      vld_p1  <= 1'b1;
      data_p1 <= beat_p0.dout;
    end else if (bus.i_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign bus.o_ready = ready;
  assign bus.o_valid = vld_p1;
  assign bus.o_data  = data_p1;
  assign o_lock      = lock_p1;

endmodule

// File: tb/tb_scram_codec.sv
// Bench for scram_codec: two 8-bit instances (scramble -> descramble chain) and one
// 1-bit instance, checked against a coded-bit-history model and fixed vectors.
module tb_scram_codec;

  localparam int         L  = 5;
  localparam logic [4:0] TP = 5'b00101;

  logic clk = 1'b0;
  logic rst_n;
  logic clr_a, clr_b, clr_c;
  logic lock_a, lock_b, lock_c;

  scram_codec_if #(.DATA_W(8)) bus_a ();
  scram_codec_if #(.DATA_W(8)) bus_b ();
  scram_codec_if #(.DATA_W(1)) bus_c ();

  scram_codec #(.LFSR_LEN(5), .TAPS(5'b00101), .DATA_W(8)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clr_a), .bus(bus_a), .o_lock(lock_a));
  scram_codec #(.LFSR_LEN(5), .TAPS(5'b00101), .DATA_W(8)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clr_b), .bus(bus_b), .o_lock(lock_b));
  scram_codec #(.LFSR_LEN(5), .TAPS(5'b00101), .DATA_W(1)) u_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clr_c), .bus(bus_c), .o_lock(lock_c));

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  bit          v_in [3];
  bit          m_in [3];
  bit          c_in [3];
  bit          r_in [3];
  logic [63:0] d_in [3];
  bit          mvld [3];
  logic [63:0] mdata[3];
  bit          hist [3][$];

  typedef struct {
    bit         clr;
    bit         mode;
    logic [7:0] din;
    logic [7:0] dout;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int width(input int id);
    return (id == 2) ? 1 : 8;
  endfunction

  // Model: the scrambler state is just the last L coded bits on the line.
  task automatic model_beat(input int id, input logic [63:0] d, input bit m,
                            output logic [63:0] o);
    o = '0;
    for (int k = 0; k < width(id); k++) begin
      bit fb = 1'b0;
      bit c;
      for (int t = 0; t < L; t++) begin
        if (TP[t]) begin
          int idx = hist[id].size() - L + t;
          if (idx >= 0) fb ^= hist[id][idx];
        end
      end
      o[k] = d[k] ^ fb;
      c = m ? d[k] : o[k];
      hist[id].push_back(c);
      if (hist[id].size() > L) void'(hist[id].pop_front());
    end
  endtask

  function automatic logic [63:0] model_state(input int id);
    logic [63:0] s = '0;
    for (int k = 0; k < L; k++) begin
      int idx = hist[id].size() - L + k;
      if (idx >= 0) s[k] = hist[id][idx];
    end
    return s;
  endfunction

  function automatic logic [63:0] dut_data(input int id);
    case (id)
      0:       return 64'(bus_a.o_data);
      1:       return 64'(bus_b.o_data);
      default: return 64'(bus_c.o_data);
    endcase
  endfunction

  function automatic logic [63:0] dut_vld(input int id);
    case (id)
      0:       return 64'(bus_a.o_valid);
      1:       return 64'(bus_b.o_valid);
      default: return 64'(bus_c.o_valid);
    endcase
  endfunction

  function automatic logic [63:0] dut_rdy(input int id);
    case (id)
      0:       return 64'(bus_a.o_ready);
      1:       return 64'(bus_b.o_ready);
      default: return 64'(bus_c.o_ready);
    endcase
  endfunction

  function automatic logic [63:0] dut_lock(input int id);
    case (id)
      0:       return 64'(lock_a);
      1:       return 64'(lock_b);
      default: return 64'(lock_c);
    endcase
  endfunction

  task automatic drive();
    bus_a.i_valid = v_in[0]; bus_a.i_mode = m_in[0]; bus_a.i_data = d_in[0][7:0];
    bus_a.i_ready = r_in[0]; clr_a = c_in[0];
    bus_b.i_valid = v_in[1]; bus_b.i_mode = m_in[1]; bus_b.i_data = d_in[1][7:0];
    bus_b.i_ready = r_in[1]; clr_b = c_in[1];
    bus_c.i_valid = v_in[2]; bus_c.i_mode = m_in[2]; bus_c.i_data = d_in[2][0:0];
    bus_c.i_ready = r_in[2]; clr_c = c_in[2];
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mvld[i] = 1'b0;
      hist[i].delete();
    end
  endtask

  // One clock for all three instances; entered and left at posedge+1.
  task automatic tick();
    logic [63:0] o;
    bit acc;
    drive();
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ready%0d", i), dut_rdy(i), 64'(!mvld[i] || r_in[i]));
      acc = v_in[i] && (!mvld[i] || r_in[i]) && !c_in[i];
      if (c_in[i]) hist[i].delete();
      if (acc) begin
        model_beat(i, d_in[i], m_in[i], o);
        mdata[i] = o;
        mvld[i]  = 1'b1;
      end else if (r_in[i]) begin
        mvld[i] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("valid%0d", i), dut_vld(i), 64'(mvld[i]));
      if (mvld[i]) chk($sformatf("data%0d", i), dut_data(i), mdata[i]);
      chk($sformatf("lock%0d", i), dut_lock(i), 64'(hist[i].size() >= L));
    end
  endtask

  initial begin
    logic [7:0] pt[$];
    tbl[0] = '{1'b1, 1'b0, 8'h01, 8'h69};
    tbl[1] = '{1'b1, 1'b1, 8'h69, 8'h01};
    tbl[2] = '{1'b1, 1'b0, 8'hFF, 8'h27};
    tbl[3] = '{1'b1, 1'b1, 8'h27, 8'hFF};
    tbl[4] = '{1'b1, 1'b0, 8'h00, 8'h00};
    tbl[5] = '{1'b1, 1'b0, 8'h01, 8'h69};
    tbl[6] = '{1'b0, 1'b0, 8'h00, 8'h3E};
    tbl[7] = '{1'b1, 1'b0, 8'h01, 8'h69};
    tbl[8] = '{1'b0, 1'b1, 8'h3E, 8'h00};

    for (int i = 0; i < 3; i++) begin
      v_in[i] = 0; m_in[i] = 0; c_in[i] = 0; r_in[i] = 1; d_in[i] = '0;
    end
    model_reset();
    rst_n = 1'b0;
    drive();
    #3;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_valid%0d", i), dut_vld(i), 64'd0);
      chk($sformatf("rst_data%0d", i), dut_data(i), 64'd0);
      chk($sformatf("rst_lock%0d", i), dut_lock(i), 64'd0);
    end
    chk("rst_shift", 64'(u_a.r_shift), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Fixed vectors on instance A
    for (int i = 0; i < 9; i++) begin
      if (tbl[i].clr) begin
        c_in[0] = 1; v_in[0] = 0;
        tick();
        c_in[0] = 0;
        chk("tbl_clr_lock", 64'(lock_a), 64'd0);
      end
      v_in[0] = 1; m_in[0] = tbl[i].mode; d_in[0] = 64'(tbl[i].din);
      tick();
      v_in[0] = 0;
      chk($sformatf("tbl_out%0d", i), 64'(bus_a.o_data), 64'(tbl[i].dout));
      chk($sformatf("tbl_lock%0d", i), 64'(lock_a), 64'd1);
      if (i == 0) chk("tbl_shift", 64'(u_a.r_shift), 64'h0D);
    end

    // Scramble on A feeding descramble on B, B starting from a different state
    c_in[0] = 1; c_in[1] = 1;
    tick();
    c_in[0] = 0; c_in[1] = 0;
    v_in[1] = 1; m_in[1] = 1; d_in[1] = 64'($urandom_range(1, 255));
    tick();
    v_in[1] = 0;
    for (int i = 0; i <= 256; i++) begin
      if (i < 256) begin
        v_in[0] = 1; m_in[0] = 0; d_in[0] = 64'($urandom_range(0, 255));
        pt.push_back(d_in[0][7:0]);
      end else begin
        v_in[0] = 0;
      end
      v_in[1] = mvld[0]; m_in[1] = 1; d_in[1] = mdata[0];
      tick();
      if (i >= 2) chk("chain_plain", 64'(bus_b.o_data), 64'(pt[i-1]));
    end
    v_in[0] = 0; v_in[1] = 0;
    tick();

    // 1-bit instance in descramble mode: lock after the 5th bit, stream one clock late
    c_in[2] = 1;
    tick();
    c_in[2] = 0;
    for (int k = 0; k < 45; k++) begin
      v_in[2] = 1; m_in[2] = 1; d_in[2] = 64'($urandom_range(0, 1));
      tick();
      if (k < 5) chk($sformatf("w1_lock%0d", k), 64'(lock_c), 64'(k == 4));
    end
    v_in[2] = 0;
    tick();

    // Backpressure on A
    c_in[0] = 1;
    tick();
    c_in[0] = 0;
    v_in[0] = 1; m_in[0] = 0; d_in[0] = 64'($urandom_range(0, 255));
    tick();
    r_in[0] = 0; d_in[0] = 64'($urandom_range(0, 255));
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_ready", 64'(bus_a.o_ready), 64'd0);
      chk("bp_shift", 64'(u_a.r_shift), model_state(0));
    end
    r_in[0] = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("bp_shift_run", 64'(u_a.r_shift), model_state(0));
      d_in[0] = 64'($urandom_range(0, 255));
    end

    // Clear mid-stream with a beat offered
    c_in[0] = 1; d_in[0] = 64'($urandom_range(0, 255));
    tick();
    c_in[0] = 0;
    chk("clr_lock", 64'(lock_a), 64'd0);
    chk("clr_shift", 64'(u_a.r_shift), 64'd0);
    d_in[0] = 64'h01;
    tick();
    chk("clr_next", 64'(bus_a.o_data), 64'h69);

    // Async reset in the middle of streaming
    d_in[0] = 64'($urandom_range(0, 255));
    tick();
    v_in[0] = 0; drive();
    rst_n = 1'b0;
    #2;
    chk("arst_valid", 64'(bus_a.o_valid), 64'd0);
    chk("arst_lock", 64'(lock_a), 64'd0);
    chk("arst_data", 64'(bus_a.o_data), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    v_in[0] = 1; m_in[0] = 0; d_in[0] = 64'h01;
    tick();
    v_in[0] = 0;
    chk("arst_next", 64'(bus_a.o_data), 64'h69);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
